seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 94 +++++++++
 tb/tb_seg7_scan_driver.sv | 120 ++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed, double-buffered 7-segment scan driver with guard blanking
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   digits_in/blank_mask/dp_mask  packed digits and per-digit masks, captured on load
//   load                   1-cycle capture strobe; new data becomes visible at the next frame start
//   seg/dp/an              registered segment, decimal point and anode drives (polarity applied)
//   frame_start            1-cycle pulse when the outputs first show slot 0 of a new frame
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE = 50000,
  parameter int GUARD = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic SEG_INV = SEG_ACTIVE_LOW != 0;
  localparam logic AN_INV = AN_ACTIVE_LOW != 0;
  localparam logic [6:0] SEG_OFF = {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_INV}};
  logic [CW-1:0] cnt;
  logic [SW-1:0] slot;
  logic [NUM_DIGITS-1:0][3:0] pend_d, act_d;
  logic [NUM_DIGITS-1:0] pend_b, pend_p, act_b, act_p, one_hot;
  logic pending_valid, fe_d, tick, frame_end, guard_ok, dp_on;
  logic [6:0] raw, seg_on;
  assign tick = cnt == CW'(PRESCALE - 1);
  assign frame_end = tick && slot == SW'(NUM_DIGITS - 1);
  assign one_hot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << slot;
  generate
    if (GUARD == 0) begin : g_noguard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      assign guard_ok = cnt >= CW'(GUARD);
    end
  endgenerate
  always_comb begin
    case (act_d[slot])
      4'h0: raw = 7'h3F;
      4'h1: raw = 7'h06;
      4'h2: raw = 7'h5B;
      4'h3: raw = 7'h4F;
      4'h4: raw = 7'h66;
      4'h5: raw = 7'h6D;
      4'h6: raw = 7'h7D;
      4'h7: raw = 7'h07;
      4'h8: raw = 7'h7F;
      4'h9: raw = 7'h6F;
      4'hF: raw = 7'h00;
      default: raw = 7'h40;
    endcase
  end
  assign seg_on = act_b[slot] ? 7'h00 : raw;
  assign dp_on = !act_b[slot] && act_p[slot];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      slot <= '0;
      pending_valid <= 1'b0;
      act_d <= '1;
      act_b <= '0;
      act_p <= '0;
      fe_d <= 1'b0;
      frame_start <= 1'b0;
      seg <= SEG_OFF;
      dp <= SEG_INV;
      an <= AN_OFF;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) slot <= frame_end ? '0 : slot + 1'b1;
      if (load) {pend_d, pend_b, pend_p} <= {digits_in, blank_mask, dp_mask};
      pending_valid <= frame_end ? 1'b0 : pending_valid | load;
      // a load landing on frame_end skips the pending stage so it is not lost
      if (frame_end && load) {act_d, act_b, act_p} <= {digits_in, blank_mask, dp_mask};
      else if (frame_end && pending_valid) {act_d, act_b, act_p} <= {pend_d, pend_b, pend_p};
      fe_d <= frame_end;
      frame_start <= fe_d;
      seg <= seg_on ^ {7{SEG_INV}};
      dp <= dp_on ^ SEG_INV;
      an <= guard_ok ? one_hot ^ AN_OFF : AN_OFF;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for seg7_scan_driver (4 digits, prescale 4, guard 1)
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] blank_mask = '0;
  logic [3:0] dp_mask = '0;
  logic load = 1'b0;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  logic frame_start;
  int vectors = 0;
  int miscompares = 0;
  seg7_scan_driver #(
    .NUM_DIGITS(4),
    .PRESCALE(4),
    .GUARD(1),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digits_in(digits_in),
    .blank_mask(blank_mask),
    .dp_mask(dp_mask),
    .load(load),
    .seg(seg),
    .dp(dp),
    .an(an),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask
  task automatic cyc(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e, input logic dp_e, input logic fs_e);
    tick;
    vectors++;
    assert (an === an_e) else begin miscompares++; $error("FAIL %s an got %b want %b", tag, an, an_e); end
    assert (seg === seg_e) else begin miscompares++; $error("FAIL %s seg got %h want %h", tag, seg, seg_e); end
    assert (dp === dp_e) else begin miscompares++; $error("FAIL %s dp got %b want %b", tag, dp, dp_e); end
    assert (frame_start === fs_e) else begin miscompares++; $error("FAIL %s frame_start got %b want %b", tag, frame_start, fs_e); end
  endtask
  task automatic slot_chk(input string tag, input int s, input logic [6:0] seg_e, input logic dp_e, input logic fs0, input logic ld_last);
    logic [3:0] an_e;
    an_e = ~(4'b0001 << s);
    cyc(tag, 4'hF, seg_e, dp_e, fs0);
    for (int i = 1; i < 4; i++) begin
      if (ld_last && i == 3) load = 1'b1;
      cyc(tag, an_e, seg_e, dp_e, 1'b0);
    end
  endtask
  task automatic set_in(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    digits_in = d;
    blank_mask = b;
    dp_mask = p;
  endtask
  task automatic pv_chk(input string tag);
    vectors++;
    assert (dut.pending_valid === 1'b0) else begin miscompares++; $error("FAIL %s pending_valid got %b want 0", tag, dut.pending_valid); end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) cyc("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst_n = 1'b1;
    slot_chk("f0s0", 0, 7'h7F, 1'b1, 1'b0, 1'b0);
    slot_chk("f0s1", 1, 7'h7F, 1'b1, 1'b0, 1'b0);
    set_in(16'h1234, 4'h0, 4'h0);
    load = 1'b1;
    slot_chk("f0s2", 2, 7'h7F, 1'b1, 1'b0, 1'b0);
    slot_chk("f0s3", 3, 7'h7F, 1'b1, 1'b0, 1'b0);
    slot_chk("ld_s0", 0, ~7'h66, 1'b1, 1'b1, 1'b0);
    set_in(16'h0000, 4'h0, 4'h0);
    load = 1'b1;
    slot_chk("ld_s1", 1, ~7'h4F, 1'b1, 1'b0, 1'b0);
    set_in(16'h9999, 4'h0, 4'h0);
    load = 1'b1;
    slot_chk("ld_s2", 2, ~7'h5B, 1'b1, 1'b0, 1'b0);
    slot_chk("ld_s3", 3, ~7'h06, 1'b1, 1'b0, 1'b0);
    slot_chk("last_s0", 0, ~7'h6F, 1'b1, 1'b1, 1'b0);
    set_in(16'h5555, 4'h0, 4'h0);
    load = 1'b1;
    slot_chk("last_s1", 1, ~7'h6F, 1'b1, 1'b0, 1'b0);
    slot_chk("last_s2", 2, ~7'h6F, 1'b1, 1'b0, 1'b0);
    set_in(16'h00AF, 4'h0, 4'h0);
    slot_chk("last_s3", 3, ~7'h6F, 1'b1, 1'b0, 1'b1);
    pv_chk("bypass_pv");
    slot_chk("byp_s0", 0, 7'h7F, 1'b1, 1'b1, 1'b0);
    set_in(16'h8888, 4'b1000, 4'b0100);
    load = 1'b1;
    slot_chk("byp_s1", 1, ~7'h40, 1'b1, 1'b0, 1'b0);
    slot_chk("byp_s2", 2, ~7'h3F, 1'b1, 1'b0, 1'b0);
    slot_chk("byp_s3", 3, ~7'h3F, 1'b1, 1'b0, 1'b0);
    slot_chk("mask_s0", 0, ~7'h7F, 1'b1, 1'b1, 1'b0);
    slot_chk("mask_s1", 1, ~7'h7F, 1'b1, 1'b0, 1'b0);
    slot_chk("mask_s2", 2, ~7'h7F, 1'b0, 1'b0, 1'b0);
    slot_chk("mask_s3", 3, 7'h7F, 1'b1, 1'b0, 1'b0);
    set_in(16'h1111, 4'h0, 4'h0);
    load = 1'b1;
    slot_chk("pre_rst_s0", 0, ~7'h7F, 1'b1, 1'b1, 1'b0);
    slot_chk("pre_rst_s1", 1, ~7'h7F, 1'b1, 1'b0, 1'b0);
    cyc("pre_rst_s2", 4'hF, ~7'h7F, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc("mid_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
    cyc("mid_rst2", 4'hF, 7'h7F, 1'b1, 1'b0);
    pv_chk("rst_pv");
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) slot_chk("post_f0", s, 7'h7F, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) slot_chk("post_f1", s, 7'h7F, 1'b1, s == 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
